// File: rtl/microseq_stack.sv
// Microprogram sequencer: registered microword, eight next-address ops and a
// LIFO return-address stack with sticky overflow/underflow flag.
module microseq_stack #(
  parameter int CW    = 34,
  parameter int AW    = 8,
  parameter int SELW  = 3,
  parameter int DEPTH = 4,
  localparam int NCOND = 2**SELW,
  localparam int UW    = 3 + 1 + SELW + AW + CW,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [UW-1:0]    UWORD,
  output logic [AW-1:0]    UADDR,
  input  logic [NCOND-1:0] COND_VEC,
  input  logic [AW-1:0]    DISPATCH_ADDR,
  input  logic             HOLD,
  output logic [CW-1:0]    CU,
  output logic [AW-1:0]    UPC,
  output logic [LW-1:0]    STK_LEVEL,
  output logic             STK_ERR
);

  typedef enum logic [2:0] {
    NS_JUMP, NS_DISPATCH, NS_INC, NS_CBR, NS_CWAIT, NS_CALL, NS_RET, NS_CRET
  } ns_e;

  logic [UW-1:0] ctl_q;
  logic [AW-1:0] upc_q, upc_d;
  logic [AW-1:0] stk_q [DEPTH];
  logic [LW-1:0] lvl_q;
  logic          err_q;

  ns_e             ns;
  logic            inv;
  logic [SELW-1:0] sel;
  logic [AW-1:0]   target;
  logic [AW-1:0]   inc;
  logic            cond;
  logic            full, empty;
  logic            push, pop, err_set;

  assign ns     = ns_e'(ctl_q[UW-1 -: 3]);
  assign inv    = ctl_q[UW-4];
  assign sel    = ctl_q[UW-5 -: SELW];
  assign target = ctl_q[CW +: AW];
  assign inc    = upc_q + AW'(1);
  assign cond   = COND_VEC[sel] ^ inv;
  assign full   = (lvl_q == LW'(DEPTH));
  assign empty  = (lvl_q == '0);

  always_comb begin
    upc_d   = inc;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    case (ns)
      NS_JUMP:     upc_d = target;
      NS_DISPATCH: upc_d = DISPATCH_ADDR;
      NS_INC:      upc_d = inc;
      NS_CBR:      upc_d = cond ? target : inc;
      NS_CWAIT:    upc_d = cond ? inc : upc_q;
      NS_CALL: begin
        upc_d = target;
        if (full) err_set = 1'b1;
        else      push    = 1'b1;
      end
      NS_RET, NS_CRET: begin
        if (ns == NS_RET || cond) begin
          // Popping an empty stack restarts at address 0 and flags the error.
          if (empty) begin
            upc_d   = '0;
            err_set = 1'b1;
          end else begin
            upc_d = stk_q[0];
            pop   = 1'b1;
          end
        end
      end
      default: upc_d = inc;
    endcase
  end

  assign UADDR = RESET ? upc_d : '0;

  // stk_q[0] is the top of stack; push shifts down, pop shifts up.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ctl_q <= '0;
      upc_q <= '0;
      lvl_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else if (!HOLD) begin
      ctl_q <= UWORD;
      upc_q <= upc_d;
      err_q <= err_q | err_set;
      if (push) begin
        stk_q[0] <= inc;
        for (int i = 1; i < DEPTH; i++) stk_q[i] <= stk_q[i-1];
        lvl_q <= lvl_q + LW'(1);
      end else if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) stk_q[i] <= stk_q[i+1];
        stk_q[DEPTH-1] <= '0;
        lvl_q <= lvl_q - LW'(1);
      end
    end
  end

  assign CU        = ctl_q[CW-1:0];
  assign UPC       = upc_q;
  assign STK_LEVEL = lvl_q;
  assign STK_ERR   = err_q;

endmodule

// File: tb/tb_microseq_stack.sv
// Bench for microseq_stack: directed scenarios plus random ROM/condition runs
// compared against a queue-based sequencer model.
module tb_microseq_stack;
  localparam int CW = 34, AW = 8, SELW = 3, DEPTH = 4;
  localparam int UW = 3 + 1 + SELW + AW + CW;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          HOLD = 1'b0;
  logic [UW-1:0] UWORD;
  logic [AW-1:0] UADDR;
  logic [7:0]    COND_VEC = '0;
  logic [AW-1:0] DISPATCH_ADDR = '0;
  logic [CW-1:0] CU;
  logic [AW-1:0] UPC;
  logic [2:0]    STK_LEVEL;
  logic          STK_ERR;

  logic [UW-1:0] rom [256];
  assign UWORD = rom[UADDR];

  microseq_stack #(.CW(CW), .AW(AW), .SELW(SELW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .UWORD(UWORD), .UADDR(UADDR), .COND_VEC(COND_VEC),
    .DISPATCH_ADDR(DISPATCH_ADDR), .HOLD(HOLD), .CU(CU), .UPC(UPC),
    .STK_LEVEL(STK_LEVEL), .STK_ERR(STK_ERR)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  logic [UW-1:0] m_ctl;
  int            m_upc;
  int            m_stk[$];
  bit            m_err;

  function automatic logic [UW-1:0] mk(int ns, int inv, int sel, int tgt, longint ctl);
    return {ns[2:0], inv[0], sel[2:0], tgt[7:0], ctl[33:0]};
  endfunction

  function automatic int m_next(input int cv, input int da, output bit ps, output bit pp, output bit er);
    int ns, inv, sel, tgt, inc;
    bit c;
    ns  = int'(m_ctl[48:46]);
    inv = int'(m_ctl[45]);
    sel = int'(m_ctl[44:42]);
    tgt = int'(m_ctl[41:34]);
    inc = (m_upc + 1) % 256;
    c   = (((cv >> sel) & 1) != inv);
    ps = 0; pp = 0; er = 0;
    case (ns)
      0: return tgt;
      1: return da;
      2: return inc;
      3: return c ? tgt : inc;
      4: return c ? inc : m_upc;
      5: begin
        if (m_stk.size() == DEPTH) er = 1; else ps = 1;
        return tgt;
      end
      default: begin
        if (ns == 7 && !c) return inc;
        if (m_stk.size() == 0) begin er = 1; return 0; end
        pp = 1;
        return m_stk[$];
      end
    endcase
  endfunction

  task automatic tick();
    int a;
    bit ps, pp, er;
    a = m_next(int'(COND_VEC), int'(DISPATCH_ADDR), ps, pp, er);
    @(posedge CLK);
    if (!HOLD) begin
      if (ps) m_stk.push_back((m_upc + 1) % 256);
      if (pp) void'(m_stk.pop_back());
      if (er) m_err = 1;
      m_upc = a;
      m_ctl = rom[a];
    end
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    HOLD = 1'b0;
    #1;
    m_ctl = '0; m_upc = 0; m_stk.delete(); m_err = 0;
    @(posedge CLK);
    #3;
    RESET = 1'b1;
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = mk(2, 0, 0, 0, 'h155);
    RESET = 1'b0;
    #2;
    n_chk++; if (CU !== '0) begin n_fail++; $display("FAIL reset_cu: CU=%h want 0", CU); end
    n_chk++; if (UADDR !== 8'h00) begin n_fail++; $display("FAIL reset_uaddr: UADDR=%h want 00", UADDR); end
    n_chk++; if ({UPC, STK_LEVEL, STK_ERR} !== '0) begin n_fail++; $display("FAIL reset_state: UPC=%h lvl=%0d err=%b want 0", UPC, STK_LEVEL, STK_ERR); end
    do_reset();
    tick();
    n_chk++; if (CU !== 34'h155) begin n_fail++; $display("FAIL fetch_cu: CU=%h want 155", CU); end
    n_chk++; if (UPC !== 8'h00) begin n_fail++; $display("FAIL fetch_upc: UPC=%h want 00", UPC); end
    n_chk++; if (UADDR !== 8'h01) begin n_fail++; $display("FAIL fetch_uaddr: UADDR=%h want 01", UADDR); end
  endtask

  task automatic test_cwait(input int inv);
    clear_rom();
    rom[0] = mk(0, 0, 0, 5, 0);
    rom[5] = mk(4, inv, 0, 0, 'h5);
    rom[6] = mk(0, 0, 0, 6, 'h6);
    COND_VEC = (inv != 0) ? 8'h01 : 8'h00;
    do_reset();
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (UPC !== 8'h05) begin n_fail++; $display("FAIL cwait_spin inv=%0d cyc=%0d: UPC=%h want 05", inv, i, UPC); end
      if (i < 3) tick();
    end
    COND_VEC = (inv != 0) ? 8'h00 : 8'h01;
    tick();
    n_chk++; if (UPC !== 8'h06) begin n_fail++; $display("FAIL cwait_exit inv=%0d: UPC=%h want 06", inv, UPC); end
    COND_VEC = '0;
  endtask

  task automatic test_calls();
    int exp_upc[7] = '{'h10, 'h40, 'h41, 'h42, 'h80, 'h43, 'h11};
    int exp_lvl[7] = '{0, 1, 1, 1, 2, 1, 0};
    clear_rom();
    rom[0]    = mk(0, 0, 0, 'h10, 0);
    rom['h10] = mk(5, 0, 0, 'h40, 1);
    rom['h40] = mk(2, 0, 0, 0, 2);
    rom['h41] = mk(2, 0, 0, 0, 3);
    rom['h42] = mk(5, 0, 0, 'h80, 4);
    rom['h80] = mk(6, 0, 0, 0, 5);
    rom['h43] = mk(6, 0, 0, 0, 6);
    rom['h11] = mk(0, 0, 0, 'h11, 7);
    do_reset();
    tick(); tick();
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      n_chk++;
      if (UPC !== exp_upc[i][7:0] || STK_LEVEL !== exp_lvl[i][2:0] || STK_ERR !== 1'b0) begin
        n_fail++;
        $display("FAIL nested_call step %0d: UPC=%h lvl=%0d err=%b want %h %0d 0", i, UPC, STK_LEVEL, STK_ERR, exp_upc[i], exp_lvl[i]);
      end
    end
  endtask

  task automatic test_stack_err();
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = mk(5, 0, 0, i + 1, i);
    rom[5] = mk(0, 0, 0, 5, 0);
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    n_chk++; if (UPC !== 8'h05) begin n_fail++; $display("FAIL overflow_jump: UPC=%h want 05", UPC); end
    n_chk++; if (STK_LEVEL !== 3'd4 || STK_ERR !== 1'b1) begin n_fail++; $display("FAIL overflow_flags: lvl=%0d err=%b want 4 1", STK_LEVEL, STK_ERR); end
    clear_rom();
    rom[0] = mk(6, 0, 0, 'h33, 0);
    do_reset();
    n_chk++; if (STK_ERR !== 1'b0) begin n_fail++; $display("FAIL err_cleared: err=%b want 0", STK_ERR); end
    tick();
    n_chk++; if (UADDR !== 8'h00) begin n_fail++; $display("FAIL underflow_uaddr: UADDR=%h want 00", UADDR); end
    tick();
    n_chk++; if (STK_ERR !== 1'b1 || STK_LEVEL !== 3'd0 || UPC !== 8'h00) begin n_fail++; $display("FAIL underflow_flags: err=%b lvl=%0d UPC=%h want 1 0 00", STK_ERR, STK_LEVEL, UPC); end
  endtask

  task automatic test_dispatch_wrap();
    clear_rom();
    rom[0]    = mk(0, 0, 0, 'h30, 0);
    rom['h30] = mk(1, 0, 0, 0, 0);
    rom['hA7] = mk(0, 0, 0, 'hFF, 0);
    rom['hFF] = mk(2, 0, 0, 0, 0);
    DISPATCH_ADDR = 8'hA7;
    do_reset();
    tick(); tick(); tick();
    n_chk++; if (UPC !== 8'hA7) begin n_fail++; $display("FAIL dispatch: UPC=%h want A7", UPC); end
    tick(); tick();
    n_chk++; if (UPC !== 8'h00) begin n_fail++; $display("FAIL inc_wrap: UPC=%h want 00", UPC); end
    clear_rom();
    rom[0] = mk(3, 0, 2, 'h60, 0);
    do_reset();
    tick();
    COND_VEC = 8'h00;
    #1;
    n_chk++; if (UADDR !== 8'h01) begin n_fail++; $display("FAIL cbr_false: UADDR=%h want 01", UADDR); end
    COND_VEC = 8'h04;
    #1;
    n_chk++; if (UADDR !== 8'h60) begin n_fail++; $display("FAIL cbr_true: UADDR=%h want 60", UADDR); end
    tick();
    n_chk++; if (UPC !== 8'h60) begin n_fail++; $display("FAIL cbr_taken: UPC=%h want 60", UPC); end
    COND_VEC = '0;
  endtask

  task automatic test_hold_reset();
    clear_rom();
    rom[0]    = mk(0, 0, 0, 'h10, 0);
    rom['h10] = mk(5, 0, 0, 'h40, 'h3);
    rom['h40] = mk(5, 0, 0, 'h50, 'h4);
    rom['h50] = mk(4, 0, 1, 0, 'h5);
    COND_VEC = '0;
    do_reset();
    tick(); tick();
    HOLD = 1'b1;
    tick(); tick();
    n_chk++; if (UPC !== 8'h10 || CU !== 34'h3 || STK_LEVEL !== 3'd0) begin n_fail++; $display("FAIL hold_freeze: UPC=%h CU=%h lvl=%0d want 10 3 0", UPC, CU, STK_LEVEL); end
    n_chk++; if (UADDR !== 8'h40) begin n_fail++; $display("FAIL hold_uaddr: UADDR=%h want 40", UADDR); end
    HOLD = 1'b0;
    tick();
    n_chk++; if (UPC !== 8'h40 || STK_LEVEL !== 3'd1) begin n_fail++; $display("FAIL hold_single_push: UPC=%h lvl=%0d want 40 1", UPC, STK_LEVEL); end
    tick(); tick();
    n_chk++; if (UPC !== 8'h50 || STK_LEVEL !== 3'd2) begin n_fail++; $display("FAIL spin_depth2: UPC=%h lvl=%0d want 50 2", UPC, STK_LEVEL); end
    RESET = 1'b0;
    #1;
    n_chk++; if ({CU, UPC, STK_LEVEL, STK_ERR, UADDR} !== '0) begin n_fail++; $display("FAIL async_reset: CU=%h UPC=%h lvl=%0d err=%b UADDR=%h want 0", CU, UPC, STK_LEVEL, STK_ERR, UADDR); end
    do_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++)
      rom[i] = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 255)), longint'({$urandom, $urandom}));
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      int  ea;
      bit  ps, pp, er;
      COND_VEC      = 8'($urandom);
      DISPATCH_ADDR = 8'($urandom);
      HOLD          = ($urandom_range(0, 7) == 0);
      #1;
      ea = m_next(int'(COND_VEC), int'(DISPATCH_ADDR), ps, pp, er);
      n_chk++; if (UADDR !== ea[7:0]) begin n_fail++; $display("FAIL rand_uaddr cyc=%0d: UADDR=%h want %h", cyc, UADDR, ea[7:0]); end
      tick();
      n_chk++;
      if (UPC !== m_upc[7:0] || CU !== m_ctl[33:0] || int'(STK_LEVEL) != m_stk.size() || STK_ERR !== m_err) begin
        n_fail++;
        $display("FAIL rand_state cyc=%0d: UPC=%h CU=%h lvl=%0d err=%b want %h %h %0d %b",
                 cyc, UPC, CU, STK_LEVEL, STK_ERR, m_upc[7:0], m_ctl[33:0], m_stk.size(), m_err);
      end
      if ($urandom_range(0, 149) == 0) do_reset();
    end
    HOLD = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cwait(0);
    test_cwait(1);
    test_calls();
    test_stack_err();
    test_dispatch_wrap();
    test_hold_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/microseq_stack.md
Name: microseq_stack

Overview:
- Parametrised microprogram sequencer. It is the next-generation successor of the fixed 8-bit-address control unit.
- Registers the current microinstruction, computes the next micro-address from eight next-state ops, and presents that address to an external combinational microcode ROM.
- New over the previous generation:
  - configurable address, control-word and condition widths
  - a hardware return-address stack (CALL/RET/conditional RET)
  - a HOLD stall input
  - stack status outputs
- Sits between the IR decode encoder / condition sources and the datapath control lines.

Parameters:
CW, 34, control-word width driven to datapath
AW, 8, micro-address width
SELW, 3, condition-select width; NCOND = 2**SELW condition inputs
DEPTH, 4, return-stack entries (>=1)

Ports:
CLK  in  1  rising-edge clock
RESET  in  1  asynchronous, active-low reset
UWORD  in  UW  microword read from ROM at UADDR; UW = 3+1+SELW+AW+CW
UADDR  out  AW  next micro-address (combinational)
COND_VEC  in  NCOND  condition inputs (MOC, COND, IR bits, LSM flags, ...)
DISPATCH_ADDR  in  AW  entry address from IR encoder
HOLD  in  1  stall; freezes all state
CU  out  CW  control word = ctl_reg[CW-1:0]
UPC  out  AW  address of microinstruction currently in ctl_reg
STK_LEVEL  out  clog2(DEPTH+1)  stack occupancy
STK_ERR  out  1  sticky stack overflow/underflow flag

Behaviour:
- Microword fields, MSB to LSB:
  - NS[2:0]
  - INV
  - SEL[SELW-1:0]
  - TARGET[AW-1:0]
  - CTL[CW-1:0]
- cond = COND_VEC[SEL] XOR INV. All fields are taken from ctl_reg.
- inc = UPC+1, computed modulo 2**AW (carry dropped; 2**AW-1 wraps to 0).
- NS ops, giving the next UADDR:
  - 0 JUMP: TARGET
  - 1 DISPATCH: DISPATCH_ADDR
  - 2 INC: inc
  - 3 CBR: cond ? TARGET : inc
  - 4 CWAIT: cond ? inc : UPC (spin, e.g. memory-wait on MOC)
  - 5 CALL: push inc; TARGET
  - 6 RET: pop top
  - 7 CRET: cond ? pop top : inc
- Timing:
  - Each CLK rise with HOLD=0: ctl_reg <= UWORD, UPC <= UADDR, stack updated.
  - A microinstruction executes for exactly one cycle; CU changes only on the clock edge.
- HOLD=1:
  - ctl_reg, UPC, stack, STK_LEVEL and STK_ERR all retain their values.
  - UADDR continues to be computed combinationally from the held state and live inputs.
  - No push or pop occurs.
- Stack: LIFO of AW-bit entries; STK_LEVEL counts entries, 0..DEPTH.
  - CALL with STK_LEVEL==DEPTH: jump still taken, push discarded, STK_LEVEL unchanged, STK_ERR<=1.
  - RET, or CRET with cond true, at STK_LEVEL==0: UADDR=0, STK_ERR<=1, level stays 0.
  - CRET with cond false: no pop.
  - Only one push or pop can occur per cycle.
- STK_ERR is sticky; it is cleared only by RESET.
- While RESET=0:
  - ctl_reg=0, UPC=0, stack emptied, STK_LEVEL=0, STK_ERR=0, CU=0.
  - UADDR forced to 0.
  - Because the all-zero microword is JUMP to 0, the first edge after RESET rises loads ROM[0] with UPC=0.
- Reset asserted mid-operation (during a spin, a held cycle, or with a non-empty stack) takes effect immediately and asynchronously; there is no residual state.
- Outputs are free of combinational paths from UWORD. UADDR depends combinationally on COND_VEC, DISPATCH_ADDR and RESET only.

Test Plan:
1. Reset/fetch: hold RESET=0, ROM[0]=INC with CTL=0x155 -> CU=0, UADDR=0 during reset. First edge after release: CU=0x155, UPC=0, UADDR=1.
2. MOC wait: ROM[5]=CWAIT SEL=0 INV=0, COND_VEC[0]=0 for 3 cycles then 1 -> UPC stays 5 for 4 cycles, then 6. Repeat with INV=1 and confirm the sense is inverted.
3. Nested calls, DEPTH=4: CALL 0x40 from 0x10, CALL 0x80 from 0x42, RET, RET -> UPC sequence 0x10, 0x40, 0x41, 0x42, 0x80, 0x43, 0x11; STK_LEVEL 0,1,1,1,2,1,0; STK_ERR=0.
4. Stack errors: 5 consecutive CALLs -> 5th still jumps, STK_LEVEL=4, STK_ERR=1. After reset, RET on empty -> UADDR=0, STK_ERR=1.
5. Dispatch and wrap, AW=8:
   - DISPATCH with DISPATCH_ADDR=0xA7 -> UPC=0xA7 next cycle.
   - INC at 0xFF -> UPC=0x00.
   - CBR with cond true/false -> TARGET / inc.
6. HOLD and reset mid-CALL: HOLD=1 for 2 cycles during CALL -> CU, UPC and STK_LEVEL frozen, no double push. Assert RESET during a CWAIT spin with STK_LEVEL=2 -> all outputs 0 at once, UADDR=0.
